mmio_bus_ctrl: RTL
==================

# mmio_bus_ctrl

Sequencer between the CPU memory stage and the MMIO peripheral slaves (buttons, switches, LEDs, UART, ...). It accepts one CPU load/store at a time and decodes the target from the slaves' `work` flags. It strobes only the selected slave, waits for that slave's `done`, and returns read data to the CPU. Unmapped, ambiguous and hung accesses complete with an error flag instead of stalling the pipeline.

## Interface
- `N_SLAVES`, default 8: number of slave ports.
- `TIMEOUT_CYCLES`, default 255: maximum WAIT cycles before abort. Used only with `MMIO_TIMEOUT_EN`; must be ≥1.

Reset `rst_n`, synchronous, active-low; clock `sys_clk`.

- `sys_clk` in, 1: clock.
- `rst_n` in, 1: synchronous active-low reset.
- `cpu_req` in, 1: access request, level.
- `cpu_we` in, 1: 1 = write, 0 = read; sampled with `cpu_req`.
- `cpu_addr` in, 32: byte address.
- `cpu_wdata` in, 32: write data.
- `cpu_ready` out, 1: one-cycle completion pulse.
- `cpu_rdata` out, 32: read data; valid while `cpu_ready`.
- `cpu_err` out, 1: error flag; valid while `cpu_ready`.
- `slv_addr` out, 32: shared address to all slaves.
- `slv_wdata` out, 32: shared write data.
- `slv_read` out, N_SLAVES: per-slave read strobe.
- `slv_write` out, N_SLAVES: per-slave write strobe.
- `slv_work` in, N_SLAVES: per-slave address-hit flag, combinational from `slv_addr`.
- `slv_done` in, N_SLAVES: per-slave completion.
- `slv_rdata` in, 32·N_SLAVES: flattened read data; slave i is at `[32i+31:32i]`.

## Operation
- States: IDLE, WAIT, RESP.
- `slv_addr`/`slv_wdata` pass `cpu_addr`/`cpu_wdata` through in IDLE. In WAIT/RESP they come from registers latched at acceptance and are held stable.
- **IDLE**, `cpu_req`=1:
  - `slv_work` one-hot: latch the index, set the selected `slv_read[i]` (`cpu_we`=0) or `slv_write[i]` (`cpu_we`=1) and go to WAIT.
  - `slv_work` zero or multi-hot: no strobe; go to RESP with err=1, rdata=0.
- `cpu_req` is ignored outside IDLE.
- **WAIT**:
  - Strobe stays high until `slv_done[sel]` is sampled 1.
  - On that edge: clear the strobe, latch `slv_rdata[sel]` into `cpu_rdata` (writes latch 0), err=0, go to RESP.
  - `done` from non-selected slaves is ignored.
- **RESP**: `cpu_ready`=1 for exactly one cycle, then IDLE. `cpu_rdata`/`cpu_err` are cleared to 0 on leaving RESP.
- Requester handshake: the requester must drop `cpu_req` in the `cpu_ready` cycle. If `cpu_req` is still high in the following IDLE cycle, a new transaction starts.
- `slv_done` pulses arriving in IDLE/RESP (late responses) are discarded.

## Timing
- Reset values: state IDLE; all `slv_read`/`slv_write` 0; `cpu_ready` 0; `cpu_rdata` 0; `cpu_err` 0.
- Reset is honoured in any state. A strobe in flight drops on the next edge, and no `cpu_ready` is produced for the aborted access.
- `cpu_req` accepted at edge T:
  - Strobe is high from T.
  - A slave with 1-cycle response raises `done` at T+1.
  - The controller captures at T+2; `cpu_ready` is high in the T+2..T+3 cycle.
  - Total: 3 cycles from request to ready.
- Decode error: `cpu_ready` is high in the cycle after acceptance, with no slave strobe ever asserted.
- At most one bit of `slv_read|slv_write` is set in any cycle.

## Configuration
- `MMIO_TIMEOUT_EN` defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` without `done`: drop the strobe and go to RESP with err=1, rdata=0.
- `MMIO_TIMEOUT_EN` undefined: no counter; WAIT lasts until `done`, and a hung slave stalls indefinitely.

## Test plan
- Read from the button slave (slot 2, `done` 1 cycle after strobe, rdata=0x1): `slv_read`=0b100 for exactly 2 cycles; `cpu_ready` 3 cycles after request with rdata=0x00000001, err=0.
- Write 0xA5A5A5A5 to slot 0: `slv_write[0]` is set and `slv_wdata`=0xA5A5A5A5 throughout WAIT; `cpu_ready` with rdata=0, err=0.
- `cpu_addr`=0x00001000 (no slave hits): no strobe; `cpu_ready` 1 cycle after acceptance, err=1, rdata=0.
- `slv_work`=0b0011 (slots 0 and 1 both hit): err=1, no strobe.
- With `MMIO_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, slave never responds: strobe drops after 4 WAIT cycles, then `cpu_ready` with err=1. A later `done` pulse produces no `cpu_ready`.
- `rst_n` low during WAIT: strobe is 0 on the next edge and no `cpu_ready` is produced. After reset releases, a fresh read completes normally.

Source files
------------

// File: rtl/mmio_bus_ctrl_if.sv
// mmio_bus_ctrl_if: CPU-side request/response and shared MMIO slave bus.
// Ports (signals):
//   cpu_req/cpu_we/cpu_addr/cpu_wdata       CPU memory stage -> controller
//   cpu_ready/cpu_rdata/cpu_err             controller -> CPU (one-cycle completion)
//   slv_addr/slv_wdata/slv_read/slv_write   controller -> slaves (one-hot strobes)
//   slv_work/slv_done/slv_rdata             slaves -> controller (slot i data at [32i+31:32i])
// Modports: master = controller, slave = CPU + peripherals side.
interface mmio_bus_ctrl_if #(parameter int N_SLAVES = 8);
  logic cpu_req;
  logic cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic cpu_ready;
  logic [31:0] cpu_rdata;
  logic cpu_err;
  logic [31:0] slv_addr;
  logic [31:0] slv_wdata;
  logic [N_SLAVES-1:0] slv_read;
  logic [N_SLAVES-1:0] slv_write;
  logic [N_SLAVES-1:0] slv_work;
  logic [N_SLAVES-1:0] slv_done;
  logic [32*N_SLAVES-1:0] slv_rdata;
  modport master (
    input cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_work, slv_done, slv_rdata,
    output cpu_ready, cpu_rdata, cpu_err, slv_addr, slv_wdata, slv_read, slv_write
  );
  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_work, slv_done, slv_rdata,
    input cpu_ready, cpu_rdata, cpu_err, slv_addr, slv_wdata, slv_read, slv_write
  );
endinterface

// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: sequences one CPU load/store at a time onto the MMIO slave that claims it.
// Ports: sys_clk (clock), rst_n (sync active-low reset), bus (mmio_bus_ctrl_if.master).
// Parameters: N_SLAVES slave slots; TIMEOUT_CYCLES WAIT limit (>=1).
// Optional macro MMIO_TIMEOUT_EN: abort a WAIT after TIMEOUT_CYCLES cycles with err=1.
module mmio_bus_ctrl #(
  parameter int N_SLAVES = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic sys_clk,
  input logic rst_n,
  mmio_bus_ctrl_if.master bus
);
  localparam int SW = N_SLAVES > 1 ? $clog2(N_SLAVES) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end
  state_t state, state_nx;
  logic [SW-1:0] sel_q, hit_idx;
  logic we_q, err_q, err_nx, one_hot, sel_done, expired;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_nx;
  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < N_SLAVES; i++)
      if (bus.slv_work[i]) hit_idx = SW'(i);
  end
  assign one_hot = bus.slv_work != '0 && (bus.slv_work & (bus.slv_work - 1'b1)) == '0;
  assign sel_done = bus.slv_done[sel_q];
`ifdef MMIO_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  // Counter is zero on WAIT entry; the edge that would make it TIMEOUT_CYCLES aborts.
  always_ff @(posedge sys_clk)
    cnt_q <= (!rst_n || state != WAIT) ? '0 : cnt_q + 1'b1;
  assign expired = cnt_q == CW'(TIMEOUT_CYCLES - 1);
`else
  assign expired = 1'b0;
`endif
  always_ff @(posedge sys_clk)
    if (!rst_n) begin
      state <= IDLE;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      rdata_q <= rdata_nx;
      err_q <= err_nx;
      // Request fields are captured every IDLE cycle, so they freeze at acceptance.
      if (state == IDLE) begin
        sel_q <= hit_idx;
        we_q <= bus.cpu_we;
        addr_q <= bus.cpu_addr;
        wdata_q <= bus.cpu_wdata;
      end
    end
  always_comb begin
    state_nx = state;
    rdata_nx = rdata_q;
    err_nx = err_q;
    if (state == IDLE && bus.cpu_req) begin
      state_nx = one_hot ? WAIT : RESP;
      rdata_nx = '0;
      err_nx = !one_hot;
    end else if (state == WAIT && (sel_done || expired)) begin
      // A done on the expiry edge still wins over the timeout.
      state_nx = RESP;
      rdata_nx = (sel_done && !we_q) ? bus.slv_rdata[32*sel_q +: 32] : '0;
      err_nx = !sel_done;
    end else if (state == RESP) begin
      state_nx = IDLE;
      rdata_nx = '0;
      err_nx = 1'b0;
    end
  end
  always_comb begin
    bus.slv_read = '0;
    bus.slv_write = '0;
    if (state == WAIT) begin
      if (we_q) bus.slv_write[sel_q] = 1'b1;
      else bus.slv_read[sel_q] = 1'b1;
    end
    bus.slv_addr = state == IDLE ? bus.cpu_addr : addr_q;
    bus.slv_wdata = state == IDLE ? bus.cpu_wdata : wdata_q;
    bus.cpu_ready = state == RESP;
    bus.cpu_rdata = rdata_q;
    bus.cpu_err = err_q;
  end
endmodule
